// File: rtl/rom_sequencer_pkg.sv
// Shared defaults and FSM state encoding for the ROM burst sequencer.
package rom_sequencer_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : rom_sequencer_pkg

// File: rtl/rom_sequencer.sv
// ROM burst sequencer: walks an external combinational ROM from start_addr
// for len words, hands each word out through a valid/ready port and keeps a
// running checksum of the words actually transferred.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start (ignored when abort is also high)
// FETCH | rom_addr = cur_addr; ROM word is captured on the next edge
// HOLD  | out_valid high, word held until out_ready accepts it
// DONE  | one-cycle done pulse, then back to IDLE
module rom_sequencer
  import rom_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  // remaining is one bit wider so that len == 0 can stand for a full 2^ADDR_W burst
  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   REM_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;

  // State and datapath registers; reset clears everything asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      checksum_q  <= checksum_d;
    end
  end

  // Next-state and datapath update; abort overrides the state transition
  // last so a word accepted in the same cycle is still summed
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    checksum_d  = checksum_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          cur_addr_d  = start_addr;
          remaining_d = (len == '0) ? REM_FULL : {1'b0, len};
          checksum_d  = '0;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        out_data_d  = rom_data;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          checksum_d  = checksum_q + out_data_q;
          out_valid_d = 1'b0;
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) begin
            state_d = ST_DONE;
          end else begin
            cur_addr_d = cur_addr_q + ADDR_ONE;
            state_d    = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end
  end

  assign rom_addr  = cur_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign checksum  = checksum_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule : rom_sequencer
